soc_system_key_store: RTL and testbench

- Parametrised successor to the HPS key RAM: a DEPTH-slot by DATA_W-bit key store.
- The HPS writes keys through an Avalon-MM slave with byteenables.
- The AES core fetches whole keys through a request/response handshake.
- Per-slot byte-coverage tracking marks a slot valid only once every byte has been written, so the core never consumes a partial key. Sits between the HPS lightweight bridge and the AES core.

---
 rtl/soc_system_key_store.sv | 177 +++++++++++++++++
 tb/tb_soc_system_key_store.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_key_store.sv
// ============================================================================
//  Module   : soc_system_key_store
//  Summary  : DEPTH x DATA_W key store. The HPS writes keys over Avalon-MM
//             with byteenables. The AES core fetches whole keys over a
//             request/response handshake.
//  Option   : define KEY_STORE_READ_PROTECT_EN to make slot reads return zero
//  Revision : 1.0
// ============================================================================
`default_nettype none

module soc_system_key_store #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4,
  parameter int SLOT_W = $clog2(DEPTH),
  parameter int AW     = SLOT_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic              key_req_valid,
  input  logic [SLOT_W-1:0] key_req_slot,
  output logic              key_req_ready,
  output logic              key_out_valid,
  output logic [DATA_W-1:0] key_out_data,
  output logic              key_out_err,
  input  logic              key_out_ready
);

  localparam int c_num_bytes = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  logic                           w_key_wr;
  logic                           w_stat_wr;
  logic                           w_rd;
  logic [DEPTH-1:0][DATA_W-1:0]   w_key;
  logic [DEPTH-1:0]               w_valid;

  // A simultaneous read and write performs only the write
  assign w_key_wr  = chipselect & write & ~address[AW-1];
  assign w_stat_wr = chipselect & write &  address[AW-1];
  assign w_rd      = chipselect & read  & ~write;

  // --------------------------------------------------------------------------
  // Per-slot storage and byte-coverage tracking
  // --------------------------------------------------------------------------
  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    logic [DATA_W-1:0]      r_key;
    logic [c_num_bytes-1:0] r_cov;
    logic                   w_hit;

    assign w_hit = w_key_wr && (address[SLOT_W-1:0] == SLOT_W'(s));

    always_ff @(posedge clk) begin
      for (int b = 0; b < c_num_bytes; b++) begin
        if (w_hit && byteenable[b]) begin
          r_key[8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end

    // Invalidate clears coverage only; the key bytes themselves stay put
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cov <= '0;
      end else if (w_stat_wr && writedata[s]) begin
        r_cov <= '0;
      end else if (w_hit) begin
        r_cov <= r_cov | byteenable;
      end
    end

    assign w_key[s]   = r_key;
    assign w_valid[s] = &r_cov;
  end

  // --------------------------------------------------------------------------
  // Avalon read port, fixed latency 1, holds between reads
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      if (address[AW-1]) begin
        r_readdata <= DATA_W'(w_valid);
      end else begin
`ifdef KEY_STORE_READ_PROTECT_EN
        r_readdata <= '0;
`else
        r_readdata <= w_key[address[SLOT_W-1:0]];
`endif
      end
    end
  end

  assign readdata = r_readdata;

  // --------------------------------------------------------------------------
  // Core fetch FSM
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [SLOT_W-1:0] r_slot;
  logic [DATA_W-1:0] r_key_data;
  logic              r_key_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    key_req_ready = 1'b0;
    key_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        key_req_ready = 1'b1;
        if (key_req_valid) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        key_out_valid = 1'b1;
        if (key_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot <= '0;
    end else if (r_state == ST_IDLE && key_req_valid) begin
      r_slot <= key_req_slot;
    end
  end

  // Sampled at the end of FETCH, so a same-cycle HPS write is not seen
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_data <= '0;
      r_key_err  <= 1'b0;
    end else if (r_state == ST_FETCH) begin
      r_key_data <= w_valid[r_slot] ? w_key[r_slot] : '0;
      r_key_err  <= ~w_valid[r_slot];
    end
  end

  assign key_out_data = r_key_data;
  assign key_out_err  = r_key_err;

endmodule

`default_nettype wire

// File: tb/tb_soc_system_key_store.sv
// ============================================================================
//  Module   : tb_soc_system_key_store
//  Summary  : Directed vector table plus hand-written collision, backpressure
//             and reset sequences for soc_system_key_store.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_soc_system_key_store;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 4;
  localparam int SLOT_W = 2;
  localparam int AW     = 3;
  localparam int NB     = DATA_W / 8;

  localparam int OP_WR      = 0;
  localparam int OP_W1C     = 1;
  localparam int OP_RD_STAT = 2;
  localparam int OP_RD_KEY  = 3;
  localparam int OP_FETCH   = 4;

  localparam logic [AW-1:0] STAT_ADDR = 3'b100;

  localparam logic [DATA_W-1:0] K2  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [DATA_W-1:0] K2N = 128'h0BADF00D0BADF00D1234123412341234;
  localparam logic [DATA_W-1:0] D1A = 128'h11111111111111112222222222222222;
  localparam logic [DATA_W-1:0] D1B = 128'h33333333333333334444444444444444;
  localparam logic [DATA_W-1:0] D1M = 128'h33333333333333332222222222222222;
  localparam logic [DATA_W-1:0] K0  = 128'hA5A5A5A55A5A5A5A0123456789ABCDEF;
  localparam logic [DATA_W-1:0] K1  = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;
  localparam logic [DATA_W-1:0] K5  = 128'hCAFEBABECAFEBABE0000111122223333;
  localparam logic [DATA_W-1:0] K3  = 128'hFEDCBA9876543210FFFFFFFF00000000;
  localparam logic [DATA_W-1:0] K3B = 128'h13579BDF02468ACE1122334455667788;
  localparam logic [DATA_W-1:0] KDB = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [NB-1:0]     byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              key_req_valid;
  logic [SLOT_W-1:0] key_req_slot;
  logic              key_req_ready;
  logic              key_out_valid;
  logic [DATA_W-1:0] key_out_data;
  logic              key_out_err;
  logic              key_out_ready;

  soc_system_key_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .chipselect    (chipselect),
    .write         (write),
    .read          (read),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .key_req_valid (key_req_valid),
    .key_req_slot  (key_req_slot),
    .key_req_ready (key_req_ready),
    .key_out_valid (key_out_valid),
    .key_out_data  (key_out_data),
    .key_out_err   (key_out_err),
    .key_out_ready (key_out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // All tasks start and end on a falling edge
  task automatic avl_wr(input logic [AW-1:0] a, input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
    address = a; writedata = d; byteenable = be; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; byteenable = '0;
  endtask

  task automatic avl_rd(input logic [AW-1:0] a, output logic [DATA_W-1:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic fetch(input string name, input logic [SLOT_W-1:0] s,
                       output logic [DATA_W-1:0] d, output logic e);
    int n;
    check_bit({name, "_req_ready"}, key_req_ready, 1'b1);
    key_req_valid = 1'b1; key_req_slot = s;
    @(negedge clk);
    key_req_valid = 1'b0;
    n = 1;
    while (!key_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_int({name, "_latency"}, n, 2);
    d = key_out_data;
    e = key_out_err;
    key_out_ready = 1'b1;
    @(negedge clk);
    key_out_ready = 1'b0;
    check_bit({name, "_valid_drop"}, key_out_valid, 1'b0);
  endtask

  function automatic logic [DATA_W-1:0] key_rd_exp(input logic [DATA_W-1:0] stored);
`ifdef KEY_STORE_READ_PROTECT_EN
    return '0;
`else
    return stored;
`endif
  endfunction

  typedef struct {
    int                op;
    int                slot;
    logic [DATA_W-1:0] data;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] exp;
    logic              err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t              v;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] fd;
    logic              fe;

    vecs.push_back('{OP_RD_STAT, 0, '0,   16'h0000, 128'h0, 1'b0});
    vecs.push_back('{OP_WR,      2, K2,   16'hFFFF, '0,     1'b0});
    vecs.push_back('{OP_RD_STAT, 0, '0,   16'h0000, 128'h4, 1'b0});
    vecs.push_back('{OP_FETCH,   2, '0,   16'h0000, K2,     1'b0});
    vecs.push_back('{OP_RD_KEY,  2, '0,   16'h0000, K2,     1'b0});
    vecs.push_back('{OP_WR,      1, D1A,  16'h00FF, '0,     1'b0});
    vecs.push_back('{OP_RD_STAT, 0, '0,   16'h0000, 128'h4, 1'b0});
    vecs.push_back('{OP_FETCH,   1, '0,   16'h0000, '0,     1'b1});
    vecs.push_back('{OP_WR,      1, D1B,  16'hFF00, '0,     1'b0});
    vecs.push_back('{OP_RD_STAT, 0, '0,   16'h0000, 128'h6, 1'b0});
    vecs.push_back('{OP_FETCH,   1, '0,   16'h0000, D1M,    1'b0});
    vecs.push_back('{OP_WR,      0, K0,   16'hFFFF, '0,     1'b0});
    vecs.push_back('{OP_WR,      3, K3,   16'hFFFF, '0,     1'b0});
    vecs.push_back('{OP_RD_STAT, 0, '0,   16'h0000, 128'hF, 1'b0});
    vecs.push_back('{OP_W1C,     0, 128'h9, 16'h0000, '0,   1'b0});
    vecs.push_back('{OP_RD_STAT, 0, '0,   16'h0000, 128'h6, 1'b0});
    vecs.push_back('{OP_FETCH,   3, '0,   16'h0000, '0,     1'b1});
    vecs.push_back('{OP_RD_KEY,  0, '0,   16'h0000, K0,     1'b0});
    vecs.push_back('{OP_WR,      3, K3B,  16'hFFFF, '0,     1'b0});
    vecs.push_back('{OP_RD_STAT, 0, '0,   16'h0000, 128'hE, 1'b0});
    vecs.push_back('{OP_FETCH,   3, '0,   16'h0000, K3B,    1'b0});
    vecs.push_back('{OP_FETCH,   0, '0,   16'h0000, '0,     1'b1});
    vecs.push_back('{OP_WR,      0, KDB,  16'hFFFF, '0,     1'b0});
    vecs.push_back('{OP_RD_KEY,  0, '0,   16'h0000, KDB,    1'b0});
    vecs.push_back('{OP_RD_STAT, 0, '0,   16'h0000, 128'hF, 1'b0});
    vecs.push_back('{OP_FETCH,   0, '0,   16'h0000, KDB,    1'b0});

    reset = 1'b1; address = '0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    byteenable = '0; writedata = '0; key_req_valid = 1'b0; key_req_slot = '0;
    key_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_readdata", readdata, '0);
    check("rst_key_data", key_out_data, '0);
    check_bit("rst_key_valid", key_out_valid, 1'b0);
    check_bit("rst_key_err", key_out_err, 1'b0);
    check_bit("rst_req_ready", key_req_ready, 1'b1);

    foreach (vecs[i]) begin
      v = vecs[i];
      case (v.op)
        OP_WR:  avl_wr({1'b0, SLOT_W'(v.slot)}, v.data, v.be);
        OP_W1C: avl_wr(STAT_ADDR, v.data, v.be);
        OP_RD_STAT: begin
          avl_rd(STAT_ADDR, rd);
          check($sformatf("v%0d_status", i), rd, v.exp);
        end
        OP_RD_KEY: begin
          avl_rd({1'b0, SLOT_W'(v.slot)}, rd);
          check($sformatf("v%0d_key_read", i), rd, key_rd_exp(v.exp));
        end
        default: begin
          fetch($sformatf("v%0d_fetch", i), SLOT_W'(v.slot), fd, fe);
          check($sformatf("v%0d_fetch_data", i), fd, v.exp);
          check_bit($sformatf("v%0d_fetch_err", i), fe, v.err);
        end
      endcase
    end

    // Read and write together: write lands, readdata holds
    avl_rd(3'b010, rd);
    check("rw_pre_read", rd, key_rd_exp(K2));
    address = 3'b010; writedata = K2N; byteenable = '1;
    chipselect = 1'b1; write = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    check("rw_readdata_hold", readdata, key_rd_exp(K2));
    avl_rd(3'b010, rd);
    check("rw_post_read", rd, key_rd_exp(K2N));

    // HPS write in the FETCH cycle, then backpressure with another write
    avl_wr(3'b000, K0, '1);
    key_req_valid = 1'b1; key_req_slot = 2'd0;
    @(negedge clk);
    key_req_valid = 1'b0;
    address = 3'b000; writedata = K1; byteenable = '1; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    check_bit("coll_valid", key_out_valid, 1'b1);
    check("coll_data", key_out_data, K0);
    check_bit("coll_err", key_out_err, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        address = 3'b000; writedata = K5; byteenable = '1; chipselect = 1'b1; write = 1'b1;
      end
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
      check($sformatf("bp%0d_data", c), key_out_data, K0);
      check_bit($sformatf("bp%0d_valid", c), key_out_valid, 1'b1);
      check_bit($sformatf("bp%0d_req_ready", c), key_req_ready, 1'b0);
    end
    key_out_ready = 1'b1;
    @(negedge clk);
    key_out_ready = 1'b0;
    check_bit("bp_valid_drop", key_out_valid, 1'b0);
    fetch("bp_refetch", 2'd0, fd, fe);
    check("bp_refetch_data", fd, K5);
    check_bit("bp_refetch_err", fe, 1'b0);

    // Reset while a response is presented
    key_req_valid = 1'b1; key_req_slot = 2'd2;
    @(negedge clk);
    key_req_valid = 1'b0;
    @(negedge clk);
    check_bit("mid_present_valid", key_out_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_bit("mid_rst_valid", key_out_valid, 1'b0);
    check_bit("mid_rst_req_ready", key_req_ready, 1'b1);
    check("mid_rst_data", key_out_data, '0);
    avl_rd(STAT_ADDR, rd);
    check("mid_rst_status", rd, '0);
    fetch("post_rst", 2'd2, fd, fe);
    check("post_rst_data", fd, '0);
    check_bit("post_rst_err", fe, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
